norm_tag_rob: RTL

Parametrised successor to the tagged normalization front-end. It allocates binary tags from a circular reorder buffer (ROB), dispatches non-zero direction vectors to an external pool of out-of-order sqrt/divide clusters, and collects their completions. It retires normalized vectors strictly in issue order through a registered valid/ready output. Compared with the previous generation it adds a generic component count and lane count, full backpressure on both sides, a zero-vector bypass, occupancy reporting and a sticky protocol-error flag.

---
 rtl/norm_tag_rob.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/norm_tag_rob.sv
// norm_tag_rob: tagged normalization front-end with a circular reorder buffer.
// Vectors are tagged and dispatched to an external out-of-order divider pool.
// Completions are written back by tag, and results retire strictly in issue
// order through a registered valid/ready output stage. When SKIP_ZERO is set,
// zero vectors skip the pool and are marked done as they are allocated.
module norm_tag_rob #(
   parameter int WIDTH     = 32,
   parameter int DIM       = 3,
   parameter int DEPTH     = 16,
   parameter int NUM_UNITS = 4,
   parameter int SKIP_ZERO = 1,
   parameter int TAG_W     = $clog2(DEPTH)
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [DIM*WIDTH-1:0]           in_data,
   output logic                           disp_valid,
   input  logic                           disp_ready,
   output logic [TAG_W-1:0]               disp_tag,
   output logic [DIM*WIDTH-1:0]           disp_data,
   input  logic [NUM_UNITS-1:0]           cpl_valid,
   input  logic [NUM_UNITS*TAG_W-1:0]     cpl_tag,
   input  logic [NUM_UNITS*DIM*WIDTH-1:0] cpl_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [DIM*WIDTH-1:0]           out_data,
   output logic                           out_zero,
   output logic [$clog2(DEPTH+1)-1:0]     occupancy,
   output logic                           err
);

   localparam int VW    = DIM * WIDTH;
   localparam int OCC_W = $clog2(DEPTH + 1);

   logic [TAG_W-1:0] head_reg;
   logic [TAG_W-1:0] tail_reg;
   logic [OCC_W-1:0] occ_reg;
   logic             out_valid_reg;
   logic [VW-1:0]    out_data_reg;
   logic             out_zero_reg;
   logic             err_reg;

   // Per-entry state, gathered from the generate blocks below
   logic [DEPTH-1:0] alloc_vec;
   logic [DEPTH-1:0] done_vec;
   logic [DEPTH-1:0] zflag_vec;
   logic [VW-1:0]    data_vec [DEPTH];

   // Unpacked views of the completion lanes
   logic [TAG_W-1:0]     lane_tag  [NUM_UNITS];
   logic [VW-1:0]        lane_data [NUM_UNITS];
   logic [NUM_UNITS-1:0] lane_dup;
   logic [NUM_UNITS-1:0] lane_ok;

   logic zero;
   logic full;
   logic accept;
   logic retire;
   logic cpl_err;

   // Input side: zero vectors only need ROB space, others also need the pool
   assign zero       = (SKIP_ZERO != 0) && (in_data == '0);
   assign full       = (occ_reg == OCC_W'(DEPTH));
   assign in_ready   = !full && (zero || disp_ready);
   assign disp_valid = in_valid && !full && !zero;
   assign disp_tag   = tail_reg;
   assign disp_data  = in_data;
   assign accept     = in_valid && in_ready;

   // Head entry moves into the output register when it is done and the slot frees up
   assign retire = done_vec[head_reg] && (!out_valid_reg || out_ready);

   genvar gi;
   for (gi = 0; gi < NUM_UNITS; gi++) begin : g_lane
      assign lane_tag[gi]  = cpl_tag[gi*TAG_W +: TAG_W];
      assign lane_data[gi] = cpl_data[gi*VW +: VW];
      // A lane writes only to a live, still-pending entry that no lower lane claims
      assign lane_ok[gi]   = cpl_valid[gi] && alloc_vec[lane_tag[gi]]
                             && !done_vec[lane_tag[gi]] && !lane_dup[gi];
   end

   // Flag lanes whose tag collides with a lower-index valid lane this cycle
   always_comb begin
      lane_dup = '0;
      for (int k = 0; k < NUM_UNITS; k++) begin
         for (int j = 0; j < k; j++) begin
            if (cpl_valid[j] && cpl_valid[k] && (lane_tag[j] == lane_tag[k])) begin
               lane_dup[k] = 1'b1;
            end
         end
      end
   end

   // Any valid lane that was refused is a protocol violation
   assign cpl_err = |(cpl_valid & ~lane_ok);

   for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic          alloc_reg;
      logic          done_reg;
      logic          zflag_reg;
      logic [VW-1:0] data_reg;
      logic          cpl_hit;
      logic [VW-1:0] cpl_wdata;
      logic          is_head;
      logic          is_tail;

      assign is_head = (head_reg == TAG_W'(gi));
      assign is_tail = (tail_reg == TAG_W'(gi));

      // Select the accepted completion lane aimed at this entry (at most one)
      always_comb begin
         cpl_hit   = 1'b0;
         cpl_wdata = lane_data[0];
         for (int k = NUM_UNITS - 1; k >= 0; k--) begin
            if (lane_ok[k] && (lane_tag[k] == TAG_W'(gi))) begin
               cpl_hit   = 1'b1;
               cpl_wdata = lane_data[k];
            end
         end
      end

      // Entry lifecycle: allocate at tail, complete by tag, free on retire
      always_ff @(posedge clk) begin
         if (reset) begin
            alloc_reg <= 1'b0;
            done_reg  <= 1'b0;
            zflag_reg <= 1'b0;
         end else if (retire && is_head) begin
            alloc_reg <= 1'b0;
            done_reg  <= 1'b0;
            zflag_reg <= 1'b0;
         end else if (accept && is_tail) begin
            alloc_reg <= 1'b1;
            done_reg  <= zero;
            zflag_reg <= zero;
         end else if (cpl_hit) begin
            done_reg  <= 1'b1;
         end
      end

      // Entry payload: zero bypass writes 0, completions write the lane data
      always_ff @(posedge clk) begin
         if (accept && is_tail && zero) begin
            data_reg <= '0;
         end else if (cpl_hit) begin
            data_reg <= cpl_wdata;
         end
      end

      assign alloc_vec[gi] = alloc_reg;
      assign done_vec[gi]  = done_reg;
      assign zflag_vec[gi] = zflag_reg;
      assign data_vec[gi]  = data_reg;
   end

   // Pointers and occupancy count; the output register is not counted
   always_ff @(posedge clk) begin
      if (reset) begin
         head_reg <= '0;
         tail_reg <= '0;
         occ_reg  <= '0;
      end else begin
         if (accept) begin
            tail_reg <= tail_reg + 1'b1;
         end
         if (retire) begin
            head_reg <= head_reg + 1'b1;
         end
         if (accept && !retire) begin
            occ_reg <= occ_reg + 1'b1;
         end else if (!accept && retire) begin
            occ_reg <= occ_reg - 1'b1;
         end
      end
   end

   // Registered output stage; data holds while stalled
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_zero_reg  <= 1'b0;
      end else if (retire) begin
         out_valid_reg <= 1'b1;
         out_data_reg  <= data_vec[head_reg];
         out_zero_reg  <= zflag_vec[head_reg];
      end else if (out_ready) begin
         out_valid_reg <= 1'b0;
      end
   end

   // Sticky protocol error, cleared only by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         err_reg <= 1'b0;
      end else if (cpl_err) begin
         err_reg <= 1'b1;
      end
   end

   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign out_zero  = out_zero_reg;
   assign occupancy = occ_reg;
   assign err       = err_reg;

endmodule
